// File: rtl/sad_pkg.sv
// Shared types and width helpers for the pipelined SAD engine.
package sad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sad_state_e;

    function automatic int sad_clog2(input int value);
        int width;
        width = 32'sd0;
        while ((32'sd1 <<< width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

    // Widest possible block SAD: BLK_PIX pixels of all-ones difference
    function automatic int sad_sum_w(input int pix_w, input int blk_pix);
        return pix_w + sad_clog2(blk_pix);
    endfunction

    function automatic int sad_tree_w(input int pix_w, input int lanes);
        return pix_w + sad_clog2(lanes);
    endfunction

    function automatic int sad_beat_w(input int beats);
        return (beats > 32'sd1) ? sad_clog2(beats) : 32'sd1;
    endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// Per-lane absolute differences (S1) and the registered lane sum (S2);
// the beat valid bit travels alongside so bubbles stay marked.
module sad_lane_tree
    import sad_pkg::*;
#(
    parameter int  LANES  = 4,
    parameter int  PIX_W  = 8,
    localparam int TREE_W = sad_tree_w(PIX_W, LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [LANES*PIX_W-1:0] i_cur,
    input  logic [LANES*PIX_W-1:0] i_ref,
    output logic                   o_valid,
    output logic [TREE_W-1:0]      o_sum
);

    logic [PIX_W-1:0]  r_diff [LANES];
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [TREE_W-1:0] r_sum;
    logic [TREE_W-1:0] w_sum;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Sum of the registered lane differences feeding S2
    always_comb begin
        w_sum = {TREE_W{1'b0}};
        for (int i = 32'sd0; i < LANES; i++) begin
            w_sum = w_sum + TREE_W'(r_diff[i]);
        end
    end

    // S1 and S2 pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 32'sd0; i < LANES; i++) begin
                r_diff[i] <= {PIX_W{1'b0}};
            end
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sum      <= {TREE_W{1'b0}};
        end else begin
            for (int i = 32'sd0; i < LANES; i++) begin
                r_diff[i] <= abs_diff(i_cur[i*PIX_W +: PIX_W], i_ref[i*PIX_W +: PIX_W]);
            end
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
            r_sum      <= w_sum;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_sum   = r_sum;

endmodule

// File: rtl/sad_pipe_engine.sv
// Pipelined multi-lane SAD engine: per-candidate accumulation, running
// minimum tracking and a search-level FSM (IDLE/RUN/DRAIN/DONE).
module sad_pipe_engine
    import sad_pkg::*;
#(
    parameter int  LANES   = 4,
    parameter int  PIX_W   = 8,
    parameter int  BLK_PIX = 16,
    parameter int  IDX_W   = 16,
    localparam int SUM_W   = sad_sum_w(PIX_W, BLK_PIX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last_cand,
    input  logic [LANES*PIX_W-1:0] cur_pix,
    input  logic [LANES*PIX_W-1:0] ref_pix,
    output logic                   sad_valid,
    output logic [SUM_W-1:0]       sad_out,
    output logic [IDX_W-1:0]       sad_idx,
    output logic                   best_valid,
    output logic [SUM_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   busy
);

    localparam int                BEATS     = BLK_PIX / LANES;
    localparam int                BEAT_W    = sad_beat_w(BEATS);
    localparam int                TREE_W    = sad_tree_w(PIX_W, LANES);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 32'sd1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(32'sd1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(32'sd1);

    sad_state_e             r_state;
    sad_state_e             w_state_nxt;
    logic [1:0]             r_drain_cnt;
    logic [BEAT_W-1:0]      r_beat;
    logic [LANES*PIX_W-1:0] r_cur;
    logic [LANES*PIX_W-1:0] r_ref;
    logic                   r_p0_valid;
    logic                   r_p0_final;
    logic                   r_p1_final;
    logic                   r_p2_final;
    logic                   w_tree_valid;
    logic [TREE_W-1:0]      w_tree_sum;
    logic [SUM_W-1:0]       r_acc;
    logic [SUM_W-1:0]       w_total;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_sad_valid;
    logic [SUM_W-1:0]       r_sad_out;
    logic [IDX_W-1:0]       r_sad_idx;
    logic                   r_best_valid;
    logic [SUM_W-1:0]       r_best_sad;
    logic [IDX_W-1:0]       r_best_idx;
    logic                   w_accept;
    logic                   w_final_beat;
    logic                   w_search_start;

    assign w_accept       = in_valid & r_in_ready;
    assign w_final_beat   = (r_beat == BEAT_LAST);
    assign w_search_start = (r_state == ST_IDLE) & start;
    assign w_total        = r_acc + SUM_W'(w_tree_sum);

    // Search sequencing; DRAIN covers the three pipeline stages after the last accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_accept && w_final_beat && in_last_cand) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 2'd2) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, status outputs and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_drain_cnt  <= 2'd0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_best_valid <= 1'b0;
            r_beat       <= {BEAT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= (w_state_nxt == ST_RUN);
            r_busy       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_best_valid <= (r_state == ST_DONE);
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= 2'd0;
            end
            if (w_search_start) begin
                r_beat <= {BEAT_W{1'b0}};
            end else if (w_accept) begin
                r_beat <= w_final_beat ? {BEAT_W{1'b0}} : (r_beat + BEAT_ONE);
            end
        end
    end

    // Input capture stage plus end-of-candidate marker aligned with S1/S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur      <= {(LANES*PIX_W){1'b0}};
            r_ref      <= {(LANES*PIX_W){1'b0}};
            r_p0_valid <= 1'b0;
            r_p0_final <= 1'b0;
            r_p1_final <= 1'b0;
            r_p2_final <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur <= cur_pix;
                r_ref <= ref_pix;
            end
            r_p0_valid <= w_accept;
            r_p0_final <= w_accept & w_final_beat;
            r_p1_final <= r_p0_final;
            r_p2_final <= r_p1_final;
        end
    end

    sad_lane_tree #(
        .LANES (LANES),
        .PIX_W (PIX_W)
    ) u_lane_tree (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_p0_valid),
        .i_cur   (r_cur),
        .i_ref   (r_ref),
        .o_valid (w_tree_valid),
        .o_sum   (w_tree_sum)
    );

    // S3: accumulate, publish per-candidate SAD, keep the strict minimum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= {SUM_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_sad_valid <= 1'b0;
            r_sad_out   <= {SUM_W{1'b0}};
            r_sad_idx   <= {IDX_W{1'b0}};
            r_best_sad  <= {SUM_W{1'b1}};
            r_best_idx  <= {IDX_W{1'b0}};
        end else begin
            r_sad_valid <= 1'b0;
            if (w_search_start) begin
                r_acc      <= {SUM_W{1'b0}};
                r_idx      <= {IDX_W{1'b0}};
                r_best_sad <= {SUM_W{1'b1}};
                r_best_idx <= {IDX_W{1'b0}};
            end else if (w_tree_valid) begin
                if (r_p2_final) begin
                    r_sad_valid <= 1'b1;
                    r_sad_out   <= w_total;
                    r_sad_idx   <= r_idx;
                    r_acc       <= {SUM_W{1'b0}};
                    r_idx       <= r_idx + IDX_ONE;
                    if (w_total < r_best_sad) begin
                        r_best_sad <= w_total;
                        r_best_idx <= r_idx;
                    end
                end else begin
                    r_acc <= w_total;
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign sad_valid  = r_sad_valid;
    assign sad_out    = r_sad_out;
    assign sad_idx    = r_sad_idx;
    assign best_valid = r_best_valid;
    assign best_sad   = r_best_sad;
    assign best_idx   = r_best_idx;

endmodule

// File: tb/tb_sad_pipe_engine.sv
// Scoreboard bench driving three engine configurations (default, IDX_W=2,
// LANES=1/BLK_PIX=4) from one shared beat stream.
module tb_sad_pipe_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last_cand;
    logic [31:0] cur_a;
    logic [31:0] ref_a;

    logic        rdy_a, sv_a, bv_a, busy_a;
    logic [11:0] so_a, bs_a;
    logic [15:0] si_a, bi_a;
    logic        rdy_i, sv_i, bv_i, busy_i;
    logic [11:0] so_i, bs_i;
    logic [1:0]  si_i, bi_i;
    logic        rdy_l, sv_l, bv_l, busy_l;
    logic [9:0]  so_l, bs_l;
    logic [15:0] si_l, bi_l;

    always #5 clk = ~clk;

    sad_pipe_engine dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .in_last_cand(in_last_cand), .cur_pix(cur_a), .ref_pix(ref_a),
        .sad_valid(sv_a), .sad_out(so_a), .sad_idx(si_a), .best_valid(bv_a),
        .best_sad(bs_a), .best_idx(bi_a), .busy(busy_a)
    );

    sad_pipe_engine #(.IDX_W(2)) dut_idx2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_i),
        .in_last_cand(in_last_cand), .cur_pix(cur_a), .ref_pix(ref_a),
        .sad_valid(sv_i), .sad_out(so_i), .sad_idx(si_i), .best_valid(bv_i),
        .best_sad(bs_i), .best_idx(bi_i), .busy(busy_i)
    );

    sad_pipe_engine #(.LANES(1), .BLK_PIX(4)) dut_lane1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_l),
        .in_last_cand(in_last_cand), .cur_pix(cur_a[7:0]), .ref_pix(ref_a[7:0]),
        .sad_valid(sv_l), .sad_out(so_l), .sad_idx(si_l), .best_valid(bv_l),
        .best_sad(bs_l), .best_idx(bi_l), .busy(busy_l)
    );

    logic        o_sv [3];
    logic        o_bv [3];
    logic [15:0] o_so [3];
    logic [15:0] o_si [3];
    logic [15:0] o_bs [3];
    logic [15:0] o_bi [3];
    assign o_sv[0] = sv_a;  assign o_sv[1] = sv_i;  assign o_sv[2] = sv_l;
    assign o_bv[0] = bv_a;  assign o_bv[1] = bv_i;  assign o_bv[2] = bv_l;
    assign o_so[0] = {4'd0, so_a};  assign o_so[1] = {4'd0, so_i};  assign o_so[2] = {6'd0, so_l};
    assign o_si[0] = si_a;          assign o_si[1] = {14'd0, si_i}; assign o_si[2] = si_l;
    assign o_bs[0] = {4'd0, bs_a};  assign o_bs[1] = {4'd0, bs_i};  assign o_bs[2] = {6'd0, bs_l};
    assign o_bi[0] = bi_a;          assign o_bi[1] = {14'd0, bi_i}; assign o_bi[2] = bi_l;

    typedef struct {
        int dut;
        int kind;
        int sad;
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   seq_idx2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_idx[3];
    int   m_best_sad[3];
    int   m_best_idx[3];
    int   last_so[3];
    int   last_si[3];
    int   last_bs[3];
    int   last_bi[3];
    int   idx_mod[3]  = '{65536, 4, 65536};
    int   sad_ones[3] = '{4095, 4095, 1023};
    int   exp_seq[5]  = '{0, 1, 2, 3, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_event(input int d, input int kind, input logic [15:0] v, input logic [15:0] ix);
        int k;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].dut == d && sb[j].kind == kind) k = j;
        checks++;
        assert (k >= 0)
        else begin
            errors++;
            $error("FAIL unexpected_pulse dut=%0d kind=%0d observed=pulse expected=none", d, kind);
        end
        if (k >= 0) begin
            chk($sformatf("d%0d_k%0d_value", d, kind), 32'(v), sb[k].sad);
            chk($sformatf("d%0d_k%0d_index", d, kind), 32'(ix), sb[k].idx);
            chk($sformatf("d%0d_k%0d_cycle", d, kind), cyc, sb[k].cyc);
            sb.delete(k);
        end
    endtask

    // Output monitor: every pulse must match the oldest pending expectation
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (o_sv[d] === 1'b1) begin
                check_event(d, 0, o_so[d], o_si[d]);
                last_so[d] = int'(o_so[d]);
                last_si[d] = int'(o_si[d]);
                if (d == 1) seq_idx2.push_back(int'(o_si[d]));
            end
            if (o_bv[d] === 1'b1) begin
                check_event(d, 1, o_bs[d], o_bi[d]);
                last_bs[d] = int'(o_bs[d]);
                last_bi[d] = int'(o_bi[d]);
            end
        end
    end

    task automatic begin_search();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_idx[d]      = 0;
            m_best_sad[d] = sad_ones[d];
            m_best_idx[d] = 0;
        end
    endtask

    task automatic drive_cand(input logic [7:0] cv, input logic [7:0] rv, input logic [7:0] spk,
                              input bit last, input int pct, input bit rnd, input bit kick);
        int s[3];
        int acc_cyc;
        int df;
        logic [7:0] c;
        logic [7:0] r;
        s = '{0, 0, 0};
        acc_cyc = 0;
        for (int b = 0; b < 4; b++) begin
            while (pct > 0 && int'($urandom_range(99, 0)) < pct) begin
                in_valid = 1'b0;
                @(negedge clk);
                chk("in_ready_bubble", 32'(rdy_a), 32'd1);
                @(posedge clk); #1;
            end
            for (int l = 0; l < 4; l++) begin
                c = rnd ? 8'($urandom_range(255, 0)) : cv;
                r = rnd ? 8'($urandom_range(255, 0)) : rv;
                if (!rnd && b == 0 && l == 0) c = cv + spk;
                cur_a[l*8 +: 8] = c;
                ref_a[l*8 +: 8] = r;
                df = (int'(c) > int'(r)) ? int'(c) - int'(r) : int'(r) - int'(c);
                s[0] += df;
                s[1] += df;
                if (l == 0) s[2] += df;
            end
            in_valid     = 1'b1;
            in_last_cand = last;
            start        = kick && (b == 1);
            @(negedge clk);
            chk("in_ready_beat", 32'(rdy_a), 32'd1);
            acc_cyc = cyc + 1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid     = 1'b0;
        in_last_cand = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sb.push_back('{d, 0, s[d], m_idx[d], acc_cyc + 3});
            if (s[d] < m_best_sad[d]) begin
                m_best_sad[d] = s[d];
                m_best_idx[d] = m_idx[d];
            end
            m_idx[d] = (m_idx[d] + 1) % idx_mod[d];
            if (last) sb.push_back('{d, 1, m_best_sad[d], m_best_idx[d], acc_cyc + 4});
        end
    endtask

    task automatic finish_search(input string tag);
        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_ready"}, 32'(rdy_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last_cand = 1'b0;
        cur_a = 32'd0; ref_a = 32'd0;
        #12;
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_sad_valid", 32'(sv_a), 32'd0);
        chk("rst_best_valid", 32'(bv_a), 32'd0);
        chk("rst_sad_out", 32'(so_a), 32'd0);
        chk("rst_best_sad_a", 32'(bs_a), 32'd4095);
        chk("rst_best_sad_l", 32'(bs_l), 32'd1023);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        begin_search();
        drive_cand(8'h10, 8'h10, 8'd0, 1'b1, 0, 1'b0, 1'b0);
        finish_search("zero");
        chk("zero_best", last_bs[0], 0);

        begin_search();
        drive_cand(8'hFF, 8'h00, 8'd0, 1'b1, 0, 1'b0, 1'b0);
        finish_search("max");
        chk("max_sad_a", last_so[0], 4080);
        chk("max_best_a", last_bs[0], 4080);
        chk("max_best_l", last_bs[2], 1020);

        for (int pass = 0; pass < 3; pass++) begin
            begin_search();
            drive_cand(8'h20, 8'h20, 8'd100, 1'b0, pass == 1 ? 40 : 0, 1'b0, 1'b0);
            drive_cand(8'h20, 8'h20, 8'd40,  1'b0, pass == 1 ? 40 : 0, 1'b0, pass == 2);
            drive_cand(8'h20, 8'h20, 8'd40,  1'b1, pass == 1 ? 40 : 0, 1'b0, 1'b0);
            finish_search($sformatf("three%0d", pass));
            chk("three_best_sad", last_bs[0], 40);
            chk("three_best_idx", last_bi[0], 1);
            chk("three_last_idx", last_si[0], 2);
            chk("three_best_idx_l", last_bi[2], 1);
        end

        begin_search();
        drive_cand(8'h00, 8'h00, 8'd0, 1'b0, 0, 1'b1, 1'b0);
        drive_cand(8'h00, 8'h00, 8'd0, 1'b0, 20, 1'b1, 1'b0);
        drive_cand(8'h00, 8'h00, 8'd0, 1'b1, 0, 1'b1, 1'b0);
        finish_search("random");

        begin_search();
        cur_a = 32'h40404040; ref_a = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_best_sad", 32'(bs_a), 32'd4095);
        chk("abort_sad_out", 32'(so_a), 32'd0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        begin_search();
        drive_cand(8'h05, 8'h05, 8'd77, 1'b1, 0, 1'b0, 1'b0);
        finish_search("after_abort");
        chk("after_abort_sad", last_so[0], 77);
        chk("after_abort_idx", last_si[0], 0);

        seq_idx2.delete();
        begin_search();
        for (int n = 0; n < 5; n++) begin
            drive_cand(8'h30, 8'h30, 8'(50 + 10 * n), n == 4, 0, 1'b0, 1'b0);
        end
        finish_search("wrap");
        chk("wrap_count", seq_idx2.size(), 5);
        for (int n = 0; n < 5 && n < seq_idx2.size(); n++) begin
            chk($sformatf("wrap_idx%0d", n), seq_idx2[n], exp_seq[n]);
        end
        chk("wrap_best_idx2", last_bi[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_pipe_engine.md
Name: sad_pipe_engine

Overview:
- Parametrised, pipelined sum-of-absolute-differences engine; successor to the fixed single-lane SAD datapath.
- Streams LANES pixel pairs per beat and accumulates one SAD per candidate block of BLK_PIX pixels.
- Tracks the minimum SAD and its candidate index across a search; reports the winner when the search ends.
- Sits beside the CPU datapath as a memory-fed accelerator.

Parameters:
- LANES, 4, pixel pairs processed per beat; power of 2, at least 1.
- PIX_W, 8, bits per pixel, unsigned.
- BLK_PIX, 16, pixels per candidate block; a multiple of LANES.
- IDX_W, 16, candidate index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a search.
- in_valid  in  1  beat valid.
- in_ready  out  1  high only in RUN.
- in_last_cand  in  1  sampled on the final beat of a candidate; marks the last candidate of the search.
- cur_pix  in  LANES*PIX_W  current-block pixels; lane i is at bits [i*PIX_W +: PIX_W].
- ref_pix  in  LANES*PIX_W  reference-block pixels.
- sad_valid  out  1  one-cycle pulse per completed candidate.
- sad_out  out  SUM_W  SAD of that candidate.
- sad_idx  out  IDX_W  index of that candidate.
- best_valid  out  1  one-cycle pulse when the search is done.
- best_sad  out  SUM_W  minimum SAD of the search.
- best_idx  out  IDX_W  index of the minimum.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset: one clock clk; reset rst is asynchronous and active-low.
  - While rst is 0, every register clears immediately and the state is IDLE.
  - All outputs read 0, except best_sad, which reads all-ones.
- Widths:
  - SUM_W = PIX_W + clog2(BLK_PIX). Overflow is impossible by construction.
  - BEATS = BLK_PIX/LANES. The beat counter runs 0..BEATS-1 and wraps.
- Handshake: a beat is accepted when in_valid & in_ready.
  - in_valid low inserts a bubble; bubbles carry a valid bit through the pipeline and alter no result.
- Pipeline, with a beat accepted at edge t:
  - S1 (edge t+1): per-lane |cur-ref|, registered, PIX_W bits.
  - S2 (edge t+2): adder-tree sum of the lanes, registered.
  - S3 (edge t+3): accumulator += sum. On the final beat of a candidate, at edge t+3:
    - sad_out = accumulated total; sad_idx = current index; sad_valid = 1 for one cycle.
    - The accumulator clears for the next candidate, with no lost beat if the next candidate's first S2 arrives the same cycle.
    - If total < best_sad (strict), best_sad and best_idx update. Ties keep the earlier index.
    - The candidate index increments and wraps modulo 2^IDX_W.
- FSM:
  - IDLE: start -> RUN. Clears best_sad to all-ones, best_idx to 0, and the index and beat counters.
  - RUN: accepts beats. The final beat of a candidate with in_last_cand = 1 -> DRAIN; in_ready drops the following cycle.
  - DRAIN: waits until the final S3 update has occurred (3 cycles after the last accept) -> DONE.
  - DONE: best_valid = 1 for exactly one cycle -> IDLE. best_sad and best_idx hold until the next start.
- start asserted in RUN, DRAIN or DONE is ignored.
- in_last_cand on a non-final beat is ignored.
- Reset mid-search aborts the search. No sad_valid or best_valid is issued for the partial data.

Decomposition:
- Package sad_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a clog2 function;
  - SUM_W derivation helpers.
- Sub-module sad_lane_tree: LANES absolute differences plus a registered adder tree (S1 and S2), parametrised on LANES and PIX_W.
- Top level holds the FSM, counters, accumulator and minimum tracker.

Test Plan:
- Defaults (4 beats per candidate). cur = ref = 0x10 on all lanes, one candidate with in_last_cand -> sad_out = 0, sad_idx = 0; best_valid pulses 4 cycles after the last accept with best_sad = 0, best_idx = 0.
- cur = 0xFF, ref = 0x00, one candidate -> sad_out = 4080 (12-bit maximum with no wrap); best_sad = 4080.
- Three candidates with SAD 100, 40, 40 -> three sad_valid pulses (100/0, 40/1, 40/2); best_sad = 40, best_idx = 1 (tie keeps the earlier index).
- Same stimulus as the three-candidate case, with in_valid deasserted on random cycles -> identical results; in_ready stays high throughout RUN.
- start pulsed in RUN -> ignored; results unchanged.
- rst = 0 asserted mid-candidate -> outputs clear immediately; after release, a new search returns a correct SAD with index restarted at 0.
- IDX_W = 2 with 5 candidates -> sad_idx sequence 0, 1, 2, 3, 0.
- LANES = 1, BLK_PIX = 4 -> correct SAD with latency unchanged.
